// File: rtl/permutation_inverse_iter.sv
// Iterative inverse ASCON permutation: one inverse round p^-1 = pc^-1 o ps^-1 o pl^-1
// per clock, round index counting down from 11 to 12-N.
module permutation_inverse_iter (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [3:0]   nb_rounds_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned STATE_W = 5 * WORD_W;
    localparam int unsigned RND_W   = 4;

    // Inverse of the ASCON 5-bit S-box, index {x0,x1,x2,x3,x4} with x0 as MSB.
    localparam logic [4:0] SBOX_INV [32] = '{
        5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
        5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
        5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
        5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t                 fsm_q;
    fsm_t                 fsm_d;
    logic [STATE_W-1:0]   state_d;
    logic [RND_W-1:0]     rnd_q;
    logic [RND_W-1:0]     rnd_d;
    logic [RND_W-1:0]     last_q;
    logic [RND_W-1:0]     last_d;
    logic [RND_W-1:0]     nb_san_c;

    // Right-rotate a 64-bit word.
    function automatic logic [WORD_W-1:0] rotr64(input logic [WORD_W-1:0] x, input logic [5:0] n);
        logic [2*WORD_W-1:0] d;
        d = {x, x} >> n;
        return d[WORD_W-1:0];
    endfunction

    // Inverse linear layer: product of L^(2^j), j=0..5, which equals L^-1 since L^64 = I.
    // A zero rotation XORs y with itself, kept deliberately.
    function automatic logic [WORD_W-1:0] pl_inv_word(input logic [WORD_W-1:0] x,
                                                      input int unsigned a,
                                                      input int unsigned b);
        logic [WORD_W-1:0] y;
        y = x;
        for (int unsigned j = 0; j < 6; j++) begin
            y = y ^ rotr64(y, 6'((a << j) % 64)) ^ rotr64(y, 6'((b << j) % 64));
        end
        return y;
    endfunction

    // One full inverse round for round index r.
    function automatic logic [STATE_W-1:0] pinv(input logic [STATE_W-1:0] s, input logic [RND_W-1:0] r);
        logic [WORD_W-1:0] w [5];
        logic [WORD_W-1:0] y [5];
        logic [4:0]        idx;
        logic [4:0]        o;
        for (int unsigned i = 0; i < 5; i++) begin
            w[i] = s[STATE_W-1-WORD_W*i -: WORD_W];
        end
        w[0] = pl_inv_word(w[0], 19, 28);
        w[1] = pl_inv_word(w[1], 61, 39);
        w[2] = pl_inv_word(w[2], 1, 6);
        w[3] = pl_inv_word(w[3], 10, 17);
        w[4] = pl_inv_word(w[4], 7, 41);
        for (int unsigned k = 0; k < WORD_W; k++) begin
            idx = {w[0][k], w[1][k], w[2][k], w[3][k], w[4][k]};
            o   = SBOX_INV[idx];
            y[0][k] = o[4];
            y[1][k] = o[3];
            y[2][k] = o[2];
            y[3][k] = o[1];
            y[4][k] = o[0];
        end
        y[2] = y[2] ^ {56'h0, 4'(4'd15 - r), r};
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    // Out-of-range round counts (0, 13..15) run the full 12 rounds.
    always_comb begin
        nb_san_c = nb_rounds_i;
        if ((nb_rounds_i == 4'd0) || (nb_rounds_i > 4'd12)) begin
            nb_san_c = 4'd12;
        end
    end

    // Next-state, datapath and round-counter logic.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_o;
        rnd_d   = rnd_q;
        last_d  = last_q;
        unique case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d = state_i;
                    rnd_d   = 4'd11;
                    last_d  = 4'(4'd12 - nb_san_c);
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = pinv(state_o, rnd_q);
                if (rnd_q == last_q) begin
                    fsm_d = DONE;
                end else begin
                    rnd_d = 4'(rnd_q - 4'd1);
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State register; busy/done are registered decodes of the next FSM state.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            state_o <= '0;
            rnd_q   <= '0;
            last_q  <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_o <= state_d;
            rnd_q   <= rnd_d;
            last_q  <= last_d;
            busy_o  <= (fsm_d == RUN);
            done_o  <= (fsm_d == DONE);
        end
    end

endmodule
